// File: rtl/s2_pkg.sv
// Shared definitions for the STWO select-cell reader: FSM states, slot/pipeline
// constants and reset values.
package s2_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } s2_state_t;

  localparam int S2_SLOTS    = 4;
  // Select driven in one cycle, latched by the cell on the next, sampled on the one after.
  localparam int S2_PIPE_LAT = 2;

  localparam s2_state_t  S2_STATE_RST = S_IDLE;
  localparam logic [1:0] S2_SLOT_RST  = 2'd0;
  localparam logic [3:0] S2_Q_RST     = 4'h0;

endpackage

// File: rtl/s2_sel_enc.sv
// Slot number to select-line encoder for the registered 4-to-1 select cell.
// Purely combinational so any initiator of the cell can reuse it.
module s2_sel_enc (
  input  logic [1:0] slot,
  output logic       a0,
  output logic       a1,
  output logic       b0,
  output logic       b1
);

  assign a0 = slot[0];
  assign a1 = slot[0];
  assign b0 = slot[1];
  assign b1 = slot[1];

endmodule

// File: rtl/s2_reader.sv
// Sequential reader for the STWO select cell: walks slots 0..3, captures the
// registered cell output and presents the nibble on a valid/ready port.
// Define S2_READER_MSB_FIRST_EN to issue slots in the order 3,2,1,0.
//
// Handshake: q_valid is high only in HOLD, q is frozen while q_valid=1, and a
// transfer happens on any rising edge where q_valid && q_ready (CLR excepted).
module s2_reader
  import s2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic             sin,
  output logic             a0,
  output logic             a1,
  output logic             b0,
  output logic             b1,
  output logic             busy,
  output logic [3:0]       q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [1:0]       dbg_state
);

  s2_state_t  state_q, state_d;
  logic [2:0] phase_q;
  logic [1:0] sel_q;
  logic       busy_q;
  logic       xfer;

  // Frame phase p issues slot_of(p) and captures the bit of slot_of(p-2).
  function automatic logic [1:0] slot_of(input logic [2:0] ph);
`ifdef S2_READER_MSB_FIRST_EN
    return ~ph[1:0];
`else
    return ph[1:0];
`endif
  endfunction

  assign xfer = (state_q == S_HOLD) && q_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (phase_q == 3'(S2_SLOTS)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_HOLD;
      S_HOLD:  if (q_ready) state_d = start ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q  <= S2_STATE_RST;
      phase_q  <= 3'd0;
      sel_q    <= S2_SLOT_RST;
      busy_q   <= 1'b0;
      q        <= S2_Q_RST;
      word_cnt <= '0;
    end else begin
      state_q <= state_d;
      // busy trails the FSM by one edge so it covers exactly the slot-issue window.
      busy_q  <= (state_q == S_ISSUE);

      if (state_d == S_ISSUE && state_q != S_ISSUE)
        phase_q <= 3'd0;
      else if (state_q == S_ISSUE || state_q == S_DRAIN)
        phase_q <= phase_q + 3'd1;

      if (state_q == S_ISSUE && phase_q < 3'(S2_SLOTS))
        sel_q <= slot_of(phase_q);
      else if (state_d == S_HOLD)
        sel_q <= S2_SLOT_RST;

      if ((state_q == S_ISSUE || state_q == S_DRAIN) && phase_q >= 3'(S2_PIPE_LAT))
        q[slot_of(phase_q - 3'(S2_PIPE_LAT))] <= sin;

      if (xfer)
        word_cnt <= word_cnt + 1'b1;
    end
  end

  s2_sel_enc u_sel_enc (
    .slot (sel_q),
    .a0   (a0),
    .a1   (a1),
    .b0   (b0),
    .b1   (b1)
  );

  assign busy      = busy_q;
  assign q_valid   = (state_q == S_HOLD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_s2_reader.sv
// Self-checking bench for s2_reader: a one-register select-cell model feeds sin,
// and a nibble queue plus handshake counter give the expected results.
module tb_s2_reader;

  localparam int CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             CLR, start, sin, q_ready;
  logic             a0, a1, b0, b1, busy, q_valid;
  logic [3:0]       q;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       dbg_state;

  s2_reader #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .CLR       (CLR),
    .start     (start),
    .sin       (sin),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .busy      (busy),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state)
  );

  // Select cell: registered 4:1 mux over d0..d3.
  logic [3:0] dcell;
  logic       cell_out;
  logic [1:0] cur_slot;
  assign cur_slot = {b0, a0};
  always @(posedge clk) cell_out <= dcell[cur_slot];
  assign sin = cell_out;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_cnt  = 0;
  logic [3:0] exp_q[$];
  bit         msb_first;

  initial begin
`ifdef S2_READER_MSB_FIRST_EN
    msb_first = 1'b1;
`else
    msb_first = 1'b0;
`endif
  end

  function automatic int exp_slot(input int k);
    return msb_first ? (3 - k) : k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    CLR = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start   = 1'($urandom_range(0, 1));
      q_ready = 1'($urandom_range(0, 1));
      step();
      check("rst_slot",  32'(cur_slot), 32'd0);
      check("rst_pair",  32'({a1, b1}), 32'({a0, b0}));
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_q",     32'(q), 32'd0);
      check("rst_valid", 32'(q_valid), 32'd0);
      check("rst_cnt",   32'(word_cnt), 32'd0);
    end
    CLR = 1'b0; start = 1'b0; q_ready = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called just after the edge that accepted start; returns just after q_valid rises.
  task automatic frame_body(input logic [3:0] d);
    dcell = d;
    exp_q.push_back(d);
    check("e0_busy",  32'(busy), 32'd0);
    check("e0_valid", 32'(q_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("slot",       32'(cur_slot), 32'(exp_slot(k)));
      check("sel_pair",   32'({a1, b1}), 32'({a0, b0}));
      check("busy_issue", 32'(busy), 32'd1);
      check("early_valid", 32'(q_valid), 32'd0);
    end
    step();
    check("busy_last",  32'(busy), 32'd1);
    check("early_valid", 32'(q_valid), 32'd0);
    step();
    check("valid_lat6", 32'(q_valid), 32'd1);
    check("busy_drop",  32'(busy), 32'd0);
    check("q_data",     32'(q), 32'(exp_q[0]));
  endtask

  task automatic hold_stall(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'($urandom_range(0, 1));
      step();
      check("stall_q",     32'(q), 32'(exp_q[0]));
      check("stall_valid", 32'(q_valid), 32'd1);
      check("stall_busy",  32'(busy), 32'd0);
      check("stall_cnt",   32'(word_cnt), 32'(exp_cnt));
    end
    start = 1'b0;
  endtask

  task automatic handshake(input logic with_start);
    check("hs_q", 32'(q), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    q_ready = 1'b1;
    start   = with_start;
    step();
    q_ready = 1'b0;
    start   = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    check("hs_cnt",   32'(word_cnt), 32'(exp_cnt));
    check("hs_valid", 32'(q_valid), 32'd0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_slot",  32'(cur_slot), 32'd0);
      check("idle_busy",  32'(busy), 32'd0);
      check("idle_valid", 32'(q_valid), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic chain;
    CLR = 1'b1; start = 1'b0; q_ready = 1'b0; dcell = 4'h0;
    step();

    do_reset();

    // single read, then backpressure with start toggling
    start_frame();
    frame_body(4'b1101);
    hold_stall(10);
    handshake(1'b0);
    check("bp_cnt", 32'(word_cnt), 32'd1);
    idle_gap(2);

    // back-to-back frames
    start_frame();
    frame_body(4'hA);
    handshake(1'b1);
    check("b2b_busy0", 32'(busy), 32'd0);
    frame_body(4'h5);
    handshake(1'b0);

    // abort in the DRAIN cycle
    start_frame();
    dcell = 4'hF;
    repeat (5) step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    exp_cnt = 0;
    check("abort_valid", 32'(q_valid), 32'd0);
    check("abort_q",     32'(q), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_cnt",   32'(word_cnt), 32'd0);
    check("abort_slot",  32'(cur_slot), 32'd0);
    idle_gap(3);
    start_frame();
    frame_body(4'h6);
    handshake(1'b0);

    // counter wrap: five transfers after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      start_frame();
      frame_body(4'($urandom_range(0, 15)));
      handshake(1'b0);
    end
    check("wrap_cnt", 32'(word_cnt), 32'd1);

    // randomized frames, stalls and chaining
    chain = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (!chain) begin
        idle_gap($urandom_range(0, 2));
        start_frame();
      end
      frame_body(4'($urandom_range(0, 15)));
      hold_stall($urandom_range(0, 3));
      chain = (i < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
      handshake(chain);
    end
    idle_gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
